// File: rtl/req_encoder_hs_pkg.sv
// Shared definitions for the request encoder: mode encodings and index-width helper.
package req_encoder_hs_pkg;

  localparam int unsigned PRIO_FIXED = 0;
  localparam int unsigned PRIO_RR    = 1;

  // Ceiling log2 for elaboration-time width derivation (v >= 2).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  localparam int unsigned N_DEFAULT = 4;
  localparam int unsigned W_DEFAULT = clog2(N_DEFAULT);

endpackage

// File: rtl/req_encoder_hs_prio_sel.sv
// Rotating priority selector: finds the first set bit of vec at or after ptr,
// wrapping from N-1 back to 0. Purely combinational.
// Ports:
//   vec        in  N  candidate request vector
//   ptr        in  W  search start position (0 gives plain lowest-index priority)
//   any        out 1  vec has at least one bit set
//   sel_idx    out W  binary index of the selected bit (0 when any=0)
//   sel_onehot out N  one-hot of the selected bit (all zero when any=0)
module req_encoder_hs_prio_sel
  import req_encoder_hs_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] sel_idx,
  output logic [N-1:0] sel_onehot
);

  // Modulo-N for sums of two values each below N.
  function automatic int unsigned wrap(input int unsigned a);
    return (a >= N) ? a - N : a;
  endfunction

  logic [N-1:0] rot;
  logic         found;
  int unsigned  first_pos;
  int unsigned  sel;

  // Rotate so ptr lands at bit 0, take lowest set bit, then map back.
  always_comb begin
    rot       = '0;
    found     = 1'b0;
    first_pos = 0;
    sel       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (k == wrap(i + 32'(ptr))) rot[i] = vec[k];
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found     = 1'b1;
        first_pos = i;
      end
    end
    sel     = found ? wrap(first_pos + 32'(ptr)) : 0;
    any     = found;
    sel_idx = W'(sel);
    for (int unsigned k = 0; k < N; k++) begin
      sel_onehot[k] = found && (k == sel);
    end
  end

endmodule

// File: rtl/req_encoder_hs.sv
// Request encoder with valid/ready output: captures request pulses, holds the ones
// that cannot be served yet, and offers them one at a time as a binary index.
// Ports:
//   clk      in  1  clock, rising edge
//   reset    in  1  asynchronous active-high reset
//   en       in  1  capture enable (draining continues when 0)
//   req      in  N  request pulses
//   ready    in  1  consumer accepts the offered index this cycle
//   valid    out 1  idx is offered
//   idx      out W  offered index (holds last value while valid=0)
//   pend     out N  waiting requests, excluding the offered one
//   overflow out 1  one-cycle pulse: a captured request hit an already-pending bit
module req_encoder_hs
  import req_encoder_hs_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned RR = PRIO_FIXED,
  localparam int unsigned W = clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] idx,
  output logic [N-1:0] pend,
  output logic         overflow
);

  logic [N-1:0] pend_q, pend_d;
  logic         valid_q, valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic         ovf_q, ovf_d;

  logic [N-1:0] reqm;
  logic [N-1:0] cand;
  logic         slot_free;
  logic [W-1:0] sel_ptr;
  logic         sel_any;
  logic [W-1:0] sel_idx;
  logic [N-1:0] sel_onehot;

  // Requests sampled this edge may be offered immediately (bypass into cand).
  assign reqm      = en ? req : '0;
  assign cand      = pend_q | reqm;
  assign slot_free = ~valid_q | ready;
  assign sel_ptr   = (RR == PRIO_RR) ? ptr_q : '0;

  req_encoder_hs_prio_sel #(
    .N (N),
    .W (W)
  ) u_prio_sel (
    .vec        (cand),
    .ptr        (sel_ptr),
    .any        (sel_any),
    .sel_idx    (sel_idx),
    .sel_onehot (sel_onehot)
  );

  // Next-state: load a new offer when the slot frees up, otherwise hold the
  // offer stable and only accumulate new requests.
  always_comb begin
    pend_d  = pend_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    ovf_d   = |(reqm & pend_q);
    if (slot_free) begin
      if (sel_any) begin
        valid_d = 1'b1;
        idx_d   = sel_idx;
        pend_d  = cand & ~sel_onehot;
        if (RR == PRIO_RR) begin
          ptr_d = (sel_idx == W'(N - 1)) ? '0 : sel_idx + W'(1);
        end
      end else begin
        valid_d = 1'b0;
        pend_d  = '0;
      end
    end else begin
      pend_d = cand;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign valid    = valid_q;
  assign idx      = idx_q;
  assign pend     = pend_q;
  assign overflow = ovf_q;

endmodule
